// File: rtl/mod3_stream_reducer.sv
// -----------------------------------------------------------------------------
// mod3_stream_reducer
//
// Sequential front-end for the matrix8x8 residue path. Consumes an arbitrarily
// long unsigned number as a valid/ready stream of DATA_W-bit beats (MSB beat
// first) and returns the residue of the whole number modulo 3, together with
// the number of beats in the message.
//
// Because 2^DATA_W == 1 (mod 3) for even DATA_W, the residue of the full
// number equals the sum of the per-beat residues mod 3. Beat order therefore
// does not matter for the arithmetic, and no wide accumulator is needed.
//
// Ports:
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   in_valid_i   in   1       beat present
//   in_ready_o   out  1       block accepts a beat this cycle (state-decoded)
//   in_data_i    in   DATA_W  beat payload, unsigned
//   in_last_i    in   1       final beat of the message
//   out_valid_o  out  1       result present
//   out_ready_i  in   1       consumer takes the result
//   out_mod_o    out  2       residue 0/1/2 (3 is never driven)
//   out_beats_o  out  CNT_W   beats accepted, saturating at MAX_BEATS
//   out_err_o    out  1       message had more than MAX_BEATS beats
// -----------------------------------------------------------------------------
module mod3_stream_reducer #(
    parameter int  DATA_W    = 8,
    parameter int  MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        out_mod_o,
    output logic [CNT_W-1:0]  out_beats_o,
    output logic              out_err_o
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if ((DATA_W % 2) != 0 || DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
        $error("mod3_stream_reducer: DATA_W must be even and in 2..32");
    end
    if (MAX_BEATS < 1) begin : g_bad_max_beats
        $error("mod3_stream_reducer: MAX_BEATS must be >= 1");
    end

    // -------------------------------------------------------------------------
    // Per-beat residue: nibble-pairwise reduction tree
    // -------------------------------------------------------------------------
    // 16 == 1 (mod 3), so a beat's residue is the mod-3 sum of its nibbles.
    // The beat is zero-padded to a power-of-two number of nibbles so the tree
    // can fold in halves without special cases.
    localparam int NIB_N  = (DATA_W + 3) / 4;
    localparam int TREE_N = 1 << $clog2(NIB_N);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    // Both operands are 0..2, so the raw sum is at most 4 and one conditional
    // subtraction is enough.
    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // 4 == 1 (mod 3): a nibble's residue is the sum of its two bit-pairs,
    // which ranges 0..6 and needs up to two subtractions of 3.
    function automatic logic [1:0] nib_mod3(input logic [3:0] n);
        logic [2:0] s;
        s = {1'b0, n[3:2]} + {1'b0, n[1:0]};
        if (s >= 3'd6) begin
            return 2'(s - 3'd6);
        end else if (s >= 3'd3) begin
            return 2'(s - 3'd3);
        end
        return s[1:0];
    endfunction

    function automatic logic [1:0] beat_mod3(input logic [DATA_W-1:0] d);
        logic [TREE_N*4-1:0] pad;
        logic [1:0]          lvl [TREE_N];
        pad = (TREE_N * 4)'(d);
        for (int i = 0; i < TREE_N; i++) begin
            lvl[i] = nib_mod3(pad[4*i +: 4]);
        end
        // Each pass combines partners 'step' apart; the result ends in lvl[0].
        for (int step = 1; step < TREE_N; step = step * 2) begin
            for (int i = 0; i < TREE_N; i = i + 2 * step) begin
                lvl[i] = add_mod3(lvl[i], lvl[i + step]);
            end
        end
        return lvl[0];
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,  // no beats accumulated
        S_ACCUM = 2'd1,  // at least one non-last beat accepted
        S_HOLD  = 2'd2   // result presented on the output
    } state_t;

    state_t             state_q,     state_d;
    logic [1:0]         acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               err_q,       err_d;
    logic [1:0]         out_mod_q,   out_mod_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;
    logic               out_err_q,   out_err_d;

    logic               accept;
    logic [1:0]         beat_res;
    logic [1:0]         acc_base,  acc_next;
    logic [CNT_W-1:0]   cnt_base,  cnt_next;
    logic               err_base,  err_next;

    // in_ready is decoded from state only; there is deliberately no path from
    // out_ready, which costs one bubble cycle between messages.
    assign in_ready_o  = (state_q != S_HOLD);
    assign out_valid_o = (state_q == S_HOLD);
    assign accept      = in_valid_i & in_ready_o;
    assign beat_res    = beat_mod3(in_data_i);

    // -------------------------------------------------------------------------
    // Datapath: next accumulator / counter / error for an accepted beat
    // -------------------------------------------------------------------------
    // NOTE: every variable driven here gets a value before any condition is
    // evaluated, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        acc_base = acc_q;
        cnt_base = cnt_q;
        err_base = err_q;
        // A beat taken in IDLE starts a fresh message regardless of leftovers.
        if (state_q == S_IDLE) begin
            acc_base = '0;
            cnt_base = '0;
            err_base = 1'b0;
        end

        acc_next = add_mod3(acc_base, beat_res);

        // The counter saturates; further beats still feed the residue.
        cnt_next = cnt_base;
        err_next = err_base;
        if (cnt_base < MAX_CNT) begin
            cnt_next = cnt_base + CNT_W'(1);
        end else begin
            err_next = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_mod_d   = out_mod_q;
        out_beats_d = out_beats_q;
        out_err_d   = out_err_q;

        unique case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    acc_d = acc_next;
                    cnt_d = cnt_next;
                    err_d = err_next;
                    if (in_last_i) begin
                        // Result registers load only here, so they stay
                        // stable for as long as the consumer stalls.
                        state_d     = S_HOLD;
                        out_mod_d   = acc_next;
                        out_beats_d = cnt_next;
                        out_err_d   = err_next;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end

            S_HOLD: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_mod_q   <= '0;
            out_beats_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_mod_q   <= out_mod_d;
            out_beats_q <= out_beats_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_mod_o   = out_mod_q;
    assign out_beats_o = out_beats_q;
    assign out_err_o   = out_err_q;

endmodule

// File: doc/mod3_stream_reducer.md
Name: mod3_stream_reducer

Overview:
- Sequential front-end for the matrix8x8 residue path.
- Consumes an arbitrarily long unsigned number as a valid/ready stream of DATA_W-bit beats, MSB beat first.
- Produces the number's mod-3 residue (0/1/2) plus a beat count on a registered valid/ready output.
- Uses the identity 2^DATA_W ≡ 1 (mod 3) for even DATA_W: residue = (sum of per-beat residues) mod 3. Wide operands can therefore be checked without a 32-bit limit.

Parameters:
- DATA_W, 8: beat width. Must be even and 2..32; elaboration $error otherwise.
- MAX_BEATS, 16: beats per message before overflow is flagged. Must be ≥1.
- CNT_W, $clog2(MAX_BEATS+1): width of the beat counter and out_beats (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat present
- in_ready  out  1  block accepts beat this cycle
- in_data  in  DATA_W  beat payload (unsigned)
- in_last  in  1  final beat of the message
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_mod  out  2  residue, only 0/1/2; 3 is never driven
- out_beats  out  CNT_W  beats accepted in the message, saturating at MAX_BEATS
- out_err  out  1  message exceeded MAX_BEATS beats

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - State goes to IDLE.
  - out_valid=0, out_mod=0, out_beats=0, out_err=0.
  - Internal accumulator and counter clear.
  - in_ready=1 from the first cycle after reset deasserts.
- States:
  - IDLE: no beats accumulated.
  - ACCUM: at least one non-last beat accepted.
  - HOLD: result presented.
- in_ready = (state != HOLD). It is purely state-decoded and has no combinational path from out_ready. A one-cycle bubble between messages is therefore intended.
- Beat accept = in_valid & in_ready. On each accept:
  - Per-beat residue r_b = in_data mod 3, computed combinationally by a nibble-pairwise reduction tree.
  - acc_next = (acc + r_b) mod 3, where acc reads as 0 in IDLE. acc is 2 bits and never holds 3.
  - cnt_next = cnt + 1 if cnt < MAX_BEATS; otherwise cnt holds and err_next = 1.
  - err is cleared on entry to a new message from IDLE.
- Transitions:
  - IDLE → ACCUM on an accept with in_last=0.
  - IDLE or ACCUM → HOLD on an accept with in_last=1.
  - ACCUM stays in ACCUM on an accept with in_last=0, and holds all state while in_valid=0.
  - HOLD → IDLE when out_valid & out_ready.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. it is visible the following cycle. A single-beat message therefore has latency 1.
- Output registers are loaded only on the last-beat accept:
  - out_mod = acc_next
  - out_beats = cnt_next
  - out_err = err_next (includes overflow on the last beat itself)
- While out_valid=1 and out_ready=0, all outputs stay stable. Changes on in_valid/in_data/in_last are ignored.
- After the handshake:
  - out_valid=0.
  - out_mod, out_beats and out_err retain their last values (don't-care to consumers).
- The overflowing message is still fully consumed up to in_last. Its residue stays arithmetically correct over all beats. Only out_beats saturates.
- in_data/in_last are ignored when in_valid=0. The stream protocol requires in_valid to hold until accepted, but the block does not check this.
- Reset mid-message or in HOLD: the partial result is discarded and there is no output. The next message starts cleanly.
- No X propagation: every state register has a reset value.

Test Plan:
- After reset, single beat in_data=0xFF, in_last=1 → next cycle out_valid=1, out_mod=0, out_beats=1, out_err=0.
- Two beats 0x01, 0x00 (value 256), last on the second → out_mod=1, out_beats=2. Then 0x02, 0x02 (value 514) → out_mod=1, out_beats=2, with one idle bubble (in_ready=0) between messages.
- Result of 0x05 held with out_ready=0 for 5 cycles while in_valid=1 with junk → in_ready=0, and out_mod=2, out_beats=1 stay stable all 5 cycles. Releasing out_ready returns in_ready=1 the next cycle.
- MAX_BEATS=16: 17 beats of 0x01 → out_mod=2 (17 mod 3), out_beats=16, out_err=1. Following single beat 0x03 → out_mod=0, out_beats=1, out_err=0.
- Assert rst after 3 beats of a message → out_valid=0 and outputs zero. A new message 0x07 → out_mod=1, out_beats=1.
- DATA_W=32: 1000 random messages of 1–20 beats with random in_valid/out_ready gaps → every result matches a bignum-mod-3 reference model; out_mod is never 3.
